// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES round sequencer: sequences key add, full rounds and final round over an external round function
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         ready,
  output logic [3:0]   round_idx,
  output logic         rk_req,
  input  logic         rk_valid,
  input  logic [127:0] rk_in,
  output logic [127:0] rnd_out,
  output logic         rnd_final,
  input  logic [127:0] rnd_in,
  output logic [127:0] data_out,
  output logic         done,
  input  logic         out_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY0  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } fsm_t;

  // Index of the last full round; the round after it omits MixColumns.
  localparam logic [3:0] LAST_FULL_IDX = 4'(NR - 1);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q;
  logic [3:0]   idx_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic; a missing round key stalls in place
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start)     fsm_d = KEY0;
      KEY0:    if (rk_valid)  fsm_d = ROUND;
      ROUND:   if (rk_valid && idx_q == LAST_FULL_IDX) fsm_d = FINAL;
      FINAL:   if (rk_valid)  fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default:                fsm_d = IDLE;
    endcase
  end

  // Outputs decoded purely from the FSM state so the handshakes stay mutually exclusive
  always_comb begin
    ready     = (fsm_q == IDLE);
    rk_req    = (fsm_q == KEY0) || (fsm_q == ROUND) || (fsm_q == FINAL);
    rnd_final = (fsm_q == FINAL);
    done      = (fsm_q == DONE);
  end

  // Block state and round index; each step consumes exactly one round key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      idx_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= data_in;
            idx_q   <= 4'd0;
          end
        end
        KEY0: begin
          if (rk_valid) begin
            state_q <= state_q ^ rk_in;
            idx_q   <= 4'd1;
          end
        end
        ROUND: begin
          if (rk_valid) begin
            state_q <= rnd_in ^ rk_in;
            idx_q   <= idx_q + 4'd1;
          end
        end
        FINAL: begin
          if (rk_valid) state_q <= rnd_in ^ rk_in;
        end
        DONE: begin
          if (out_ready) idx_q <= 4'd0;
        end
        default: begin
          state_q <= state_q;
          idx_q   <= idx_q;
        end
      endcase
    end
  end

  assign round_idx = idx_q;
  assign rnd_out   = state_q;
  assign data_out  = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed bench for aes_round_sequencer (NR=10 and NR=14)
module tb_aes_round_sequencer;

  localparam logic [127:0] K        = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_XOR_K = 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff;
  localparam logic [127:0] AES_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] data_in;
  logic         ready;
  logic [3:0]   round_idx;
  logic         rk_req;
  logic         rk_valid;
  logic [127:0] rk_in;
  logic [127:0] rnd_out;
  logic         rnd_final;
  logic [127:0] rnd_in;
  logic [127:0] data_out;
  logic         done;
  logic         out_ready;
  logic         use_aes;

  logic         start14;
  logic         ready14;
  logic [3:0]   round_idx14;
  logic         rk_req14;
  logic [127:0] rnd_out14;
  logic         rnd_final14;
  logic [127:0] data_out14;
  logic         done14;
  logic         out_ready14;

  logic [127:0] rk_tab [0:15];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ready(ready),
    .round_idx(round_idx), .rk_req(rk_req), .rk_valid(rk_valid), .rk_in(rk_in),
    .rnd_out(rnd_out), .rnd_final(rnd_final), .rnd_in(rnd_in),
    .data_out(data_out), .done(done), .out_ready(out_ready)
  );

  aes_round_sequencer #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .start(start14), .data_in(PT), .ready(ready14),
    .round_idx(round_idx14), .rk_req(rk_req14), .rk_valid(1'b1), .rk_in(K),
    .rnd_out(rnd_out14), .rnd_final(rnd_final14), .rnd_in(rnd_out14),
    .data_out(data_out14), .done(done14), .out_ready(out_ready14)
  );

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = b;
    logic [7:0] e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0] sb [16];
    logic [7:0] t  [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[rr+4*c] = sb[rr+4*((c+rr)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // External round function and key schedule seen by the NR=10 instance
  assign rnd_in = use_aes ? aes_round(rnd_out, rnd_final) : rnd_out;
  assign rk_in  = use_aes ? rk_tab[round_idx] : K;

  // ---------------- bench helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Runs one block on the NR=10 instance; optional 3-cycle key stall at index stall_at
  task automatic run_block(input logic [127:0] din, input int stall_at,
                           output int cyc, output int trace_bad, output int frozen_bad);
    int k = 0;
    bit stalled = 1'b0;
    logic [127:0] snap;
    logic [3:0]   idx_snap;
    cyc = 0; trace_bad = 0; frozen_bad = 0;
    data_in = din;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = ~din;
    while (!done && cyc < 60) begin
      if (k > 10 || round_idx != 4'(k) || rnd_final != (k == 10)) trace_bad++;
      k++;
      if (stall_at >= 0 && !stalled && round_idx == 4'(stall_at)) begin
        stalled  = 1'b1;
        snap     = data_out;
        idx_snap = round_idx;
        rk_valid = 1'b0;
        repeat (3) begin
          tick();
          cyc++;
          if (data_out !== snap || round_idx !== idx_snap || done !== 1'b0) frozen_bad++;
        end
        rk_valid = 1'b1;
      end
      tick();
      cyc++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, tb, fb, bad, seen;
    logic [127:0] snap;

    expand_key(AES_KEY);
    rst = 1'b1; start = 1'b0; data_in = '0; rk_valid = 1'b1; out_ready = 1'b0;
    use_aes = 1'b0; start14 = 1'b0; out_ready14 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",     128'(ready),     128'd1);
    chk("rst_done",      128'(done),      128'd0);
    chk("rst_rk_req",    128'(rk_req),    128'd0);
    chk("rst_rnd_final", 128'(rnd_final), 128'd0);
    chk("rst_round_idx", 128'(round_idx), 128'd0);
    chk("rst_data_out",  data_out,        128'd0);
    rst = 1'b0;
    tick();

    // Identity round: odd number of key XORs leaves data_in ^ K
    run_block(PT, -1, cyc, tb, fb);
    chk("ident_cycles", 128'(cyc), 128'd11);
    chk("ident_data",   data_out,  PT_XOR_K);
    chk("ident_trace",  128'(tb),  128'd0);
    chk("ident_idx_done", 128'(round_idx), 128'd10);
    release_out();

    // FIPS-197 AES-128 vector
    use_aes = 1'b1;
    run_block(PT, -1, cyc, tb, fb);
    chk("fips_cycles", 128'(cyc), 128'd11);
    chk("fips_data",   data_out,  AES_CT);
    chk("fips_trace",  128'(tb),  128'd0);

    // Output backpressure with start pulses that must be ignored
    snap = data_out;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start   = i[0];
      data_in = 128'h1234 + 128'(i);
      tick();
      if (done !== 1'b1 || data_out !== snap || ready !== 1'b0) bad++;
    end
    chk("bp_stable", 128'(bad), 128'd0);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("bp_exit_ready", 128'(ready),     128'd1);
    chk("bp_exit_done",  128'(done),      128'd0);
    chk("bp_exit_idx",   128'(round_idx), 128'd0);
    chk("bp_exit_data",  data_out,        snap);
    tick();
    chk("bp_no_accept",  128'(ready),     128'd1);

    // Key stall at round 5
    run_block(PT, 5, cyc, tb, fb);
    chk("stall_cycles", 128'(cyc), 128'd14);
    chk("stall_frozen", 128'(fb),  128'd0);
    chk("stall_trace",  128'(tb),  128'd0);
    chk("stall_data",   data_out,  AES_CT);
    release_out();

    // Reset mid-block at round_idx 4
    use_aes = 1'b0;
    data_in = PT; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (round_idx != 4'd4 && cyc < 30) begin tick(); cyc++; end
    chk("reach_idx4", 128'(round_idx), 128'd4);
    rst = 1'b1;
    #1;
    chk("arst_ready",     128'(ready),     128'd1);
    chk("arst_done",      128'(done),      128'd0);
    chk("arst_rk_req",    128'(rk_req),    128'd0);
    chk("arst_rnd_final", 128'(rnd_final), 128'd0);
    chk("arst_round_idx", 128'(round_idx), 128'd0);
    chk("arst_data_out",  data_out,        128'd0);
    seen = 0;
    repeat (3) begin tick(); if (done) seen++; end
    rst = 1'b0;
    repeat (15) begin tick(); if (done) seen++; end
    chk("arst_no_done", 128'(seen), 128'd0);
    run_block(PT, -1, cyc, tb, fb);
    chk("post_rst_cycles", 128'(cyc), 128'd11);
    chk("post_rst_data",   data_out,  PT_XOR_K);
    release_out();

    // NR=14 instance, identity round
    start14 = 1'b1;
    tick();
    start14 = 1'b0;
    cyc = 0;
    while (!done14 && cyc < 60) begin tick(); cyc++; end
    chk("nr14_cycles", 128'(cyc),         128'd15);
    chk("nr14_idx",    128'(round_idx14), 128'd14);
    chk("nr14_data",   data_out14,        PT_XOR_K);
    out_ready14 = 1'b1;
    tick();
    out_ready14 = 1'b0;
    chk("nr14_exit_ready", 128'(ready14), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
